// File: rtl/shift_pkg.sv
// Shared widths and types for the RV32I logical right shifter.
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef logic [XLEN-1:0]    word_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

endpackage : shift_pkg

// File: rtl/shift_right_stage.sv
// One stage of the log shifter: shifts right by the fixed distance SH
// (zero-filled) when en is set, otherwise passes the word through.
module shift_right_stage
    import shift_pkg::*;
#(
    parameter int SH = 1
) (
    input  word_t in,
    input  logic  en,
    output word_t out
);

    always_comb begin
        out = in;
        if (en) begin
            out = {{SH{1'b0}}, in[XLEN-1:SH]};
        end
    end

endmodule : shift_right_stage

// File: rtl/shift_right_logical_32b.sv
// 32-bit logical right barrel shifter (SRL/SRLI) with a combinational result
// and a registered copy for pipelined consumers.
module shift_right_logical_32b
    import shift_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  word_t  in,
    input  shamt_t shamt,
    output word_t  out,
    output word_t  out_q
);

    // stage_data[k] feeds stage k; stage_data[SHAMT_W] is the final result.
    word_t stage_data [SHAMT_W+1];

    assign stage_data[0] = in;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_right_stage #(
            .SH (1 << k)
        ) u_stage (
            .in  (stage_data[k]),
            .en  (shamt[k]),
            .out (stage_data[k+1])
        );
    end

    assign out = stage_data[SHAMT_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q <= '0;
        end else begin
            out_q <= out;
        end
    end

endmodule : shift_right_logical_32b

// File: tb/tb_shift_right_logical_32b.sv
// Self-checking bench for shift_right_logical_32b: directed vectors, random
// combinational checks and a register/reset sequence.
module tb_shift_right_logical_32b;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] in_v;
    logic [4:0]  shamt_v;
    logic [31:0] out_v;
    logic [31:0] out_q_v;

    int errors = 0;
    int checks = 0;

    shift_right_logical_32b dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in    (in_v),
        .shamt (shamt_v),
        .out   (out_v),
        .out_q (out_q_v)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: a logical right shift is unsigned division by 2**shamt.
    function automatic logic [31:0] ref_srl(input logic [31:0] x, input logic [4:0] s);
        longint unsigned num;
        longint unsigned den;
        num = longint'(x);
        den = 64'd1 << s;
        return 32'(num / den);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [4:0] s);
        in_v    = a;
        shamt_v = s;
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [4:0]  s;
        logic [31:0] prev_exp;

        rst_i   = 1'b1;
        in_v    = '0;
        shamt_v = '0;

        // Directed vectors from the plan, with literal expectations.
        apply(32'hFFFF_FFFF, 5'd0);  check("ones_sh0",  out_v, 32'hFFFF_FFFF);
        apply(32'hFFFF_FFFF, 5'd4);  check("ones_sh4",  out_v, 32'h0FFF_FFFF);
        apply(32'hFFFF_FFFF, 5'd31); check("ones_sh31", out_v, 32'h0000_0001);
        apply(32'h8000_0000, 5'd1);  check("msb_sh1",   out_v, 32'h4000_0000);
        apply(32'h8000_0000, 5'd16); check("msb_sh16",  out_v, 32'h0000_8000);
        apply(32'h1234_5678, 5'd1);  check("pat_sh1",   out_v, 32'h091A_2B3C);
        apply(32'h1234_5678, 5'd2);  check("pat_sh2",   out_v, 32'h048D_159E);
        apply(32'h1234_5678, 5'd4);  check("pat_sh4",   out_v, 32'h0123_4567);
        apply(32'h1234_5678, 5'd8);  check("pat_sh8",   out_v, 32'h0012_3456);
        apply(32'h1234_5678, 5'd16); check("pat_sh16",  out_v, 32'h0000_1234);
        apply(32'h1234_5678, 5'd0);  check("pat_sh0",   out_v, 32'h1234_5678);
        apply(32'hC000_0001, 5'd31); check("msb_sh31",  out_v, 32'h0000_0001);
        apply(32'h7FFF_FFFF, 5'd31); check("nomsb_sh31", out_v, 32'h0000_0000);
        for (int i = 0; i < 32; i++) begin
            apply(32'h0, 5'(i));
            check("zero_in", out_v, 32'h0);
        end

        // Random combinational checks.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            s = 5'($urandom_range(0, 31));
            apply(a, s);
            check("rand_comb", out_v, ref_srl(a, s));
        end

        // Reset held for two edges clears out_q; out still follows inputs.
        @(negedge clk_i);
        rst_i = 1'b1;
        apply(32'hA5A5_A5A5, 5'd3);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("rst_out_q", out_q_v, 32'h0);
        check("rst_out_comb", out_v, 32'h14B4_B4B4);

        @(negedge clk_i);
        rst_i = 1'b0;
        apply(32'hDEAD_BEEF, 5'd8);
        check("dead_comb", out_v, 32'h00DE_ADBE);
        @(posedge clk_i);
        #1;
        check("dead_out_q", out_q_v, 32'h00DE_ADBE);

        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midrst_out_q", out_q_v, 32'h0);
        check("midrst_out", out_v, 32'h00DE_ADBE);

        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rel_out_q", out_q_v, 32'h00DE_ADBE);

        // Back-to-back random operations through the register, one per cycle.
        prev_exp = 32'h00DE_ADBE;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_i);
            check("pipe_hold", out_q_v, prev_exp);
            a = $urandom;
            s = 5'($urandom_range(0, 31));
            apply(a, s);
            prev_exp = ref_srl(a, s);
            check("pipe_comb", out_v, prev_exp);
            @(posedge clk_i);
            #1;
            check("pipe_out_q", out_q_v, prev_exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_right_logical_32b

// File: doc/shift_right_logical_32b.md
Name: shift_right_logical_32b

Overview:
- 32-bit logical right barrel shifter for the RV32I ALU (SRL/SRLI path).
- Output `out` is purely combinational, zero latency, and is valid within the same cycle that `in` and `shamt` change.
- A registered copy `out_q` is also provided for pipelined consumers. It has one-cycle latency and is the only clocked state in the block.

Parameters:
- XLEN, 32, data width. Only 32 is supported. Other values are illegal.
- SHAMT_W, 5, shift-amount width. Must equal log2(XLEN).

Ports:
- clk_i  input  1  clock. Rising-edge active. Used only by the out_q register.
- rst_i  input  1  reset. Synchronous, active-high.
- in  input  32  operand to be shifted.
- shamt  input  5  shift amount, 0..31, unsigned.
- out  output  32  combinational result: `in >> shamt`, zero-filled.
- out_q  output  32  registered copy of `out`, updated every rising clk_i edge.

Behaviour:
- `out = in >> shamt` (logical shift).
  - Bits [31:32-shamt] are 0.
  - Bit i of `out` equals `in[i+shamt]` for i + shamt <= 31.
- Sign bit is never replicated. `in[31]=1` still zero-fills; there is no arithmetic mode.
- `out` is combinational only.
  - No dependence on clk_i or rst_i.
  - Must settle within one time unit of an input change in zero-delay simulation.
  - No latches.
- Structure: 5-stage log shifter. Stage k shifts by 2^k (k = 0..4) when `shamt[k]` = 1, otherwise passes through. Stages are chained LSB stage first.
- shamt = 0: `out = in`.
- shamt = 31: `out = {31'b0, in[31]}`.
- in = 0: `out = 0` for every shamt.
- X/Z handling is not required; inputs are assumed 2-state.
- out_q:
  - On a rising edge of clk_i with rst_i = 1: out_q <= 0.
  - On a rising edge of clk_i with rst_i = 0: out_q <= out.
- Reset values: out_q = 32'h0. `out` has no reset and always reflects the inputs, including while rst_i is high.
- Reset asserted mid-operation clears out_q on the next edge only. The combinational path is unaffected.
- No handshake. A new operation may start every cycle, and throughput is 1 per cycle.

Decomposition:
- Shared package `shift_pkg`:
  - localparam XLEN = 32
  - localparam SHAMT_W = 5
  - typedef `word_t` = logic [XLEN-1:0]
  - typedef `shamt_t` = logic [SHAMT_W-1:0]
- One sub-module: `shift_right_stage`.
  - Parameter SH (the fixed shift distance).
  - Ports: `in` (word_t), `en` (1 bit), `out` (word_t).
  - Behaviour: `out = en ? {SH'b0, in[XLEN-1:SH]} : in`.
  - The top instantiates it 5 times with SH = 1, 2, 4, 8, 16.

Test Plan:
- in=32'hFFFF_FFFF, shamt=0 -> out=32'hFFFF_FFFF. shamt=4 -> out=32'h0FFF_FFFF. shamt=31 -> out=32'h0000_0001.
- in=32'h8000_0000, shamt=1 -> out=32'h4000_0000 (zero-fill, no sign extension). shamt=16 -> out=32'h0000_8000.
- in=32'h1234_5678, each single-bit shamt (1, 2, 4, 8, 16) -> expected results:
  - shamt=1 -> 32'h091A_2B3C
  - shamt=2 -> 32'h048D_159E
  - shamt=4 -> 32'h0123_4567
  - shamt=8 -> 32'h0012_3456
  - shamt=16 -> 32'h0000_1234
- Random: 1000 iterations with random `in`/`shamt`. Compare `out` against the reference `in >> shamt` 1 time unit after the stimulus. Any mismatch fails.
- Register and reset sequence:
  - rst_i=1 for 2 edges -> out_q=0.
  - Release rst_i, then apply in=32'hDEAD_BEEF, shamt=8 -> `out` = 32'h00DE_ADBE immediately, and out_q = 32'h00DE_ADBE after the next rising edge.
  - Assert rst_i mid-stream -> out_q = 0 after that edge while `out` stays 32'h00DE_ADBE.
